tri_bus_arbiter: RTL and testbench

- Clocked round-robin arbiter for a shared tri-state bus built from mux_tri-style drivers.
- Takes N_REQ request lines and issues a one-hot grant plus a per-driver output enable for each tri-state buffer.
- Inserts a dead turnaround gap between owners so two drivers never contend.
- Caps tenure so no single requester starves the others.

---
 rtl/tri_bus_arbiter_pkg.sv | 24 ++
 rtl/tri_bus_arbiter_if.sv | 24 ++
 rtl/tri_bus_arbiter_rr_pick.sv | 34 +++
 rtl/tri_bus_arbiter.sv | 123 ++++++++++++
 tb/tb_tri_bus_arbiter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tri_bus_arbiter_pkg.sv
// Shared types and constants for the tri-state bus arbiter.
// Defines the FSM state encoding, counter widths and a clog2 helper.
package tri_arb_pkg;

   localparam int unsigned HOLD_W = 8;
   localparam int unsigned TURN_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_TURN  = 2'd2
   } arb_state_e;

   // Minimum width is 1 so that a 1-entry index still has a bit
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned w;
      w = 1;
      for (int unsigned i = 1; i < 32; i++) begin
         if ((32'd1 << i) < n) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/tri_bus_arbiter_if.sv
// Request/grant bundle between requesters and the tri-state bus arbiter.
// TRI_BUS_ARB_LOCK_EN adds the lock input that suppresses tenure preemption.
interface tri_bus_arbiter_if #(
   parameter int unsigned N_REQ = 4
);

   localparam int unsigned OW = tri_arb_pkg::clog2(N_REQ);

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] grant;
   logic [N_REQ-1:0] bus_en;
   logic [OW-1:0]    owner;
   logic             busy;
`ifdef TRI_BUS_ARB_LOCK_EN
   logic             lock;

   modport master (output req, output lock, input grant, input bus_en, input owner, input busy);
   modport slave  (input req, input lock, output grant, output bus_en, output owner, output busy);
`else
   modport master (output req, input grant, input bus_en, input owner, input busy);
   modport slave  (input req, output grant, output bus_en, output owner, output busy);
`endif

endinterface

// File: rtl/tri_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward
// from rr_ptr with wrap-around.
module rr_pick #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic             valid,
   output logic [IDX_W-1:0] index,
   output logic [N_REQ-1:0] onehot
);

   int unsigned      pos;
   logic [IDX_W-1:0] pos_idx;

   always_comb begin
      valid   = 1'b0;
      index   = '0;
      onehot  = '0;
      pos     = 0;
      pos_idx = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         pos     = (32'(rr_ptr) + k) % N_REQ;
         pos_idx = IDX_W'(pos);
         if (!valid && req[pos_idx]) begin
            valid           = 1'b1;
            index           = pos_idx;
            onehot[pos_idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin arbiter for a shared tri-state bus with tenure cap and dead turnaround.
// Optional TRI_BUS_ARB_LOCK_EN: lock input holds off MAX_HOLD preemption.
module tri_bus_arbiter
   import tri_arb_pkg::*;
#(
   parameter int unsigned N_REQ    = 4,
   parameter int unsigned MAX_HOLD = 8,
   parameter int unsigned TURN_CYC = 1
) (
   input logic               clock,
   input logic               reset_b,
   tri_bus_arbiter_if.slave  bus
);

   localparam int unsigned IDX_W = clog2(N_REQ);

   arb_state_e        state_q,    state_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [TURN_W-1:0] turn_cnt_q, turn_cnt_d;
   logic [IDX_W-1:0]  rr_ptr_q,   rr_ptr_d;
   logic [IDX_W-1:0]  owner_q,    owner_d;
   logic [N_REQ-1:0]  grant_q,    grant_d;
   logic              busy_q,     busy_d;

   logic              pick_valid;
   logic [IDX_W-1:0]  pick_index;
   logic [N_REQ-1:0]  pick_onehot;
   logic              lock_w;
   logic              owner_req;
   logic              at_max;

`ifdef TRI_BUS_ARB_LOCK_EN
   assign lock_w = bus.lock;
`else
   assign lock_w = 1'b0;
`endif

   assign owner_req = bus.req[owner_q];
   assign at_max    = (hold_cnt_q >= HOLD_W'(MAX_HOLD));

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req    (bus.req),
      .rr_ptr (rr_ptr_q),
      .valid  (pick_valid),
      .index  (pick_index),
      .onehot (pick_onehot)
   );

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      turn_cnt_d = turn_cnt_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      grant_d    = grant_q;
      busy_d     = busy_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               state_d    = ST_GRANT;
               grant_d    = pick_onehot;
               owner_d    = pick_index;
               hold_cnt_d = HOLD_W'(1);
               busy_d     = 1'b1;
            end
         end
         ST_GRANT: begin
            // Lock only masks the preempt; hold_cnt then saturates at MAX_HOLD
            if (!owner_req || (at_max && !lock_w)) begin
               state_d    = ST_TURN;
               grant_d    = '0;
               turn_cnt_d = TURN_W'(1);
               rr_ptr_d   = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
            end else if (!at_max) begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
         end
         ST_TURN: begin
            if (turn_cnt_q < TURN_W'(TURN_CYC)) begin
               turn_cnt_d = turn_cnt_q + TURN_W'(1);
            end else begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_b) begin
      if (!reset_b) begin
         state_q    <= ST_IDLE;
         hold_cnt_q <= '0;
         turn_cnt_q <= '0;
         rr_ptr_q   <= '0;
         owner_q    <= '0;
         grant_q    <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         turn_cnt_q <= turn_cnt_d;
         rr_ptr_q   <= rr_ptr_d;
         owner_q    <= owner_d;
         grant_q    <= grant_d;
         busy_q     <= busy_d;
      end
   end

   // grant_q is zero outside GRANT, so it doubles as the registered enable
   assign bus.grant  = grant_q;
   assign bus.bus_en = grant_q;
   assign bus.owner  = owner_q;
   assign bus.busy   = busy_q;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Self-checking bench for tri_bus_arbiter: directed table, corner sequences and
// random traffic against a tenure/dead-time model. Honours TRI_BUS_ARB_LOCK_EN.
module tb_tri_bus_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned MH = 8;
   localparam int unsigned TC = 1;

   logic clock = 1'b0;
   logic reset_b;
   logic lock_v;

   always #5 clock = ~clock;

   tri_bus_arbiter_if #(.N_REQ(N)) bus_if ();

`ifdef TRI_BUS_ARB_LOCK_EN
   assign bus_if.lock = lock_v;
`endif

   tri_bus_arbiter #(
      .N_REQ    (N),
      .MAX_HOLD (MH),
      .TURN_CYC (TC)
   ) dut (
      .clock   (clock),
      .reset_b (reset_b),
      .bus     (bus_if)
   );

   int checks = 0;
   int errors = 0;

   // Model: tenure = cycles owned so far (0 = not owning), dead = turnaround cycles left
   int m_owner, m_tenure, m_dead, m_ptr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner  = 0;
      m_tenure = 0;
      m_dead   = 0;
      m_ptr    = 0;
   endtask

   task automatic model_step();
      logic [N-1:0] r;
      r = bus_if.req;
      if (m_tenure > 0) begin
         if (!r[m_owner[1:0]] || (m_tenure >= MH && !lock_v)) begin
            m_tenure = 0;
            m_dead   = TC;
            m_ptr    = (m_owner + 1) % N;
         end else if (m_tenure < MH) begin
            m_tenure++;
         end
      end else if (m_dead > 0) begin
         m_dead--;
      end else begin
         for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (r[idx[1:0]]) begin
               m_owner  = idx;
               m_tenure = 1;
               break;
            end
         end
      end
   endtask

   task automatic chk_model(input string tag);
      logic [N-1:0] eg;
      eg = (m_tenure > 0) ? (4'b0001 << m_owner) : 4'b0000;
      chk({tag, "_grant"}, 32'(bus_if.grant), 32'(eg));
      chk({tag, "_bus_en"}, 32'(bus_if.bus_en), 32'(eg));
      chk({tag, "_owner"}, 32'(bus_if.owner), 32'(m_owner));
      chk({tag, "_busy"}, 32'(bus_if.busy), 32'((m_tenure > 0) || (m_dead > 0)));
   endtask

   // Called at a negedge: drive req, let one active edge pass, return at next negedge
   task automatic tick(input logic [N-1:0] r);
      bus_if.req = r;
      @(posedge clock);
      model_step();
      @(negedge clock);
   endtask

   task automatic apply_reset();
      reset_b    = 1'b0;
      bus_if.req = '0;
      lock_v     = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset_b = 1'b1;
      model_reset();
   endtask

   // Bus safety: at most one enable, and no direct hand-over between drivers
   logic [N-1:0] prev_en = '0;
   always @(negedge clock) begin
      if (reset_b === 1'b1) begin
         chk("onehot0_bus_en", 32'($onehot0(bus_if.bus_en)), 32'd1);
         chk("no_direct_handover",
             32'((prev_en != 0) && (bus_if.bus_en != 0) && (bus_if.bus_en != prev_en)), 32'd0);
         prev_en <= bus_if.bus_en;
      end else begin
         prev_en <= '0;
      end
   end

   typedef struct {
      logic [N-1:0] req;
      logic [N-1:0] grant;
      logic [1:0]   owner;
      logic         busy;
   } vec_t;

   vec_t tbl[13];

   initial begin
      logic [N-1:0] g, pg, r;
      int           len;
      logic [N-1:0] order[$];
      int           lens[$];

      reset_b    = 1'b0;
      lock_v     = 1'b0;
      bus_if.req = '1;
      model_reset();

      tbl[0]  = '{4'b0100, 4'b0100, 2'd2, 1'b1};
      tbl[1]  = '{4'b0100, 4'b0100, 2'd2, 1'b1};
      tbl[2]  = '{4'b0100, 4'b0100, 2'd2, 1'b1};
      tbl[3]  = '{4'b0000, 4'b0000, 2'd2, 1'b1};
      tbl[4]  = '{4'b0000, 4'b0000, 2'd2, 1'b0};
      tbl[5]  = '{4'b0101, 4'b0001, 2'd0, 1'b1};
      tbl[6]  = '{4'b0000, 4'b0000, 2'd0, 1'b1};
      tbl[7]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
      tbl[8]  = '{4'b1010, 4'b0010, 2'd1, 1'b1};
      tbl[9]  = '{4'b1000, 4'b0000, 2'd1, 1'b1};
      tbl[10] = '{4'b1000, 4'b0000, 2'd1, 1'b0};
      tbl[11] = '{4'b1000, 4'b1000, 2'd3, 1'b1};
      tbl[12] = '{4'b0000, 4'b0000, 2'd3, 1'b1};

      // Reset held with all requests active
      repeat (3) @(negedge clock);
      chk("reset_grant", 32'(bus_if.grant), 32'd0);
      chk("reset_bus_en", 32'(bus_if.bus_en), 32'd0);
      chk("reset_busy", 32'(bus_if.busy), 32'd0);
      chk("reset_owner", 32'(bus_if.owner), 32'd0);
      reset_b = 1'b1;

      // Rotation with all four requesting
      pg  = '0;
      len = 0;
      for (int i = 0; i < 44; i++) begin
         tick(4'b1111);
         if (i == 0) chk("first_grant_after_reset", 32'(bus_if.grant), 32'h1);
         chk_model("rot");
         g = bus_if.grant;
         if (g != 0 && pg == 0) order.push_back(g);
         if (g != 0) len++;
         if (g == 0 && pg != 0) begin
            lens.push_back(len);
            len = 0;
         end
         pg = g;
      end
      chk("rot_order_count", 32'(order.size() >= 5), 32'd1);
      if (order.size() >= 5) begin
         chk("rot_order0", 32'(order[0]), 32'h1);
         chk("rot_order1", 32'(order[1]), 32'h2);
         chk("rot_order2", 32'(order[2]), 32'h4);
         chk("rot_order3", 32'(order[3]), 32'h8);
         chk("rot_order4", 32'(order[4]), 32'h1);
      end
      foreach (lens[i]) chk("rot_tenure_len", 32'(lens[i]), 32'(MH));

      // Directed table: release, wrap-around priority, ignored requests during turnaround
      apply_reset();
      for (int i = 0; i < 13; i++) begin
         tick(tbl[i].req);
         chk($sformatf("tbl%0d_grant", i), 32'(bus_if.grant), 32'(tbl[i].grant));
         chk($sformatf("tbl%0d_bus_en", i), 32'(bus_if.bus_en), 32'(tbl[i].grant));
         chk($sformatf("tbl%0d_owner", i), 32'(bus_if.owner), 32'(tbl[i].owner));
         chk($sformatf("tbl%0d_busy", i), 32'(bus_if.busy), 32'(tbl[i].busy));
      end

      // Preempt: owner 0 never releases, bus must move to requester 1
      apply_reset();
      for (int i = 1; i <= 12; i++) begin
         tick(4'b0011);
         chk_model("preempt");
         if (i == MH)     chk("preempt_last_hold", 32'(bus_if.grant), 32'h1);
         if (i == MH + 1) chk("preempt_dead", 32'(bus_if.bus_en), 32'h0);
         if (i == MH + 3) chk("preempt_next_owner", 32'(bus_if.grant), 32'h2);
      end

`ifdef TRI_BUS_ARB_LOCK_EN
      // Lock keeps owner 0 past MAX_HOLD until it releases
      apply_reset();
      lock_v = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick(4'b0011);
         chk("lock_hold", 32'(bus_if.grant), 32'h1);
      end
      tick(4'b0010);
      chk("lock_release", 32'(bus_if.grant), 32'h0);
      chk("lock_release_busy", 32'(bus_if.busy), 32'h1);
      lock_v = 1'b0;
`endif

      // Asynchronous reset between edges during a tenure
      apply_reset();
      tick(4'b0100);
      chk("async_pre_grant", 32'(bus_if.bus_en), 32'h4);
      @(posedge clock);
      #2 reset_b = 1'b0;
      #1;
      chk("async_bus_en", 32'(bus_if.bus_en), 32'h0);
      chk("async_grant", 32'(bus_if.grant), 32'h0);
      chk("async_busy", 32'(bus_if.busy), 32'h0);
      chk("async_owner", 32'(bus_if.owner), 32'h0);
      @(negedge clock);
      reset_b = 1'b1;
      model_reset();
      bus_if.req = '0;

      // Random traffic with sticky requests so tenures of varied length occur
      r = '0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) r = N'($urandom);
`ifdef TRI_BUS_ARB_LOCK_EN
         lock_v = ($urandom_range(0, 3) == 0);
`endif
         tick(r);
         chk_model("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
